seg7_scan_driver: RTL and testbench

- Consumes the four 5-bit display digit codes that the pipeline top drives (ones, tens, hundreds, thousands) and drives a 4-digit common-anode multiplexed seven-segment display.
- Captures the digit codes once per frame, so every frame shows one consistent snapshot.
- Time-multiplexes the anodes using a prescaled scan counter and decodes each code to segments.
- Sits between the pipeline top's digit outputs and the board pins.

---
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 99 +++++++++
 tb/tb_seg7_scan_driver.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Digit-code and display-pin bundle for the 4-digit multiplexed seven-segment driver.
// The master side drives the digit codes; the slave side is the scan driver itself.
interface seg7_scan_driver_if;
  logic [4:0] oneIn;
  logic [4:0] tenIn;
  logic [4:0] hundIn;
  logic [4:0] thouIn;
  logic [3:0] dp;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp_n;
  logic       frame_tick;

  modport master (
    output oneIn, tenIn, hundIn, thouIn, dp, blank,
    input  an, seg, dp_n, frame_tick
  );

  modport slave (
    input  oneIn, tenIn, hundIn, thouIn, dp, blank,
    output an, seg, dp_n, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode seven-segment scan driver with a per-frame input snapshot.
// Outputs are registered from next-state scan index and shadow, so anodes never overlap.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 20
) (
  input logic               clock,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] PCNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [4:0]       CODE_BLANK = 5'd16;

  logic [CNT_W-1:0] pcnt_r;
  logic [1:0]       idx_r;
  logic [3:0][4:0]  code_r;
  logic [3:0]       sdp_r;

  logic             wrap_s;
  logic             snap_s;
  logic [CNT_W-1:0] pcnt_nxt_s;
  logic [1:0]       idx_nxt_s;
  logic [3:0][4:0]  code_nxt_s;
  logic [3:0]       sdp_nxt_s;

  // Active-low segment pattern for a digit code; everything not listed is blank.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'd0:    pat = 7'h3F;
      5'd1:    pat = 7'h06;
      5'd2:    pat = 7'h5B;
      5'd3:    pat = 7'h4F;
      5'd4:    pat = 7'h66;
      5'd5:    pat = 7'h6D;
      5'd6:    pat = 7'h7D;
      5'd7:    pat = 7'h07;
      5'd8:    pat = 7'h7F;
      5'd9:    pat = 7'h6F;
      5'd10:   pat = 7'h77;
      5'd11:   pat = 7'h7C;
      5'd12:   pat = 7'h39;
      5'd13:   pat = 7'h5E;
      5'd14:   pat = 7'h79;
      5'd15:   pat = 7'h71;
      5'd17:   pat = 7'h40;
      default: pat = 7'h00;
    endcase
    return ~pat;
  endfunction

  // Next-state prescaler, scan index and frame snapshot.
  always_comb begin
    wrap_s     = (pcnt_r == PCNT_LAST);
    snap_s     = 1'b0;
    pcnt_nxt_s = pcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    idx_nxt_s  = idx_r;
    code_nxt_s = code_r;
    sdp_nxt_s  = sdp_r;
    if (wrap_s) begin
      pcnt_nxt_s = {CNT_W{1'b0}};
      idx_nxt_s  = idx_r + 2'd1;
      snap_s     = (idx_r == 2'd3);
    end else begin
      pcnt_nxt_s = pcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (snap_s) begin
      code_nxt_s = {bus.thouIn, bus.hundIn, bus.tenIn, bus.oneIn};
      sdp_nxt_s  = bus.dp;
    end else begin
      code_nxt_s = code_r;
    end
  end

  // State and pin registers; pins follow the next-state index on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_r         <= {CNT_W{1'b0}};
      idx_r          <= 2'd0;
      code_r         <= {4{CODE_BLANK}};
      sdp_r          <= 4'b0000;
      bus.an         <= 4'b1111;
      bus.seg        <= 7'h7F;
      bus.dp_n       <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      pcnt_r         <= pcnt_nxt_s;
      idx_r          <= idx_nxt_s;
      code_r         <= code_nxt_s;
      sdp_r          <= sdp_nxt_s;
      bus.an         <= bus.blank ? 4'b1111 : ~(4'b0001 << idx_nxt_s);
      bus.seg        <= decode(code_nxt_s[idx_nxt_s]);
      bus.dp_n       <= ~sdp_nxt_s[idx_nxt_s];
      bus.frame_tick <= snap_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised self-checking bench for seg7_scan_driver with a cycle-count based reference model.
module tb_seg7_scan_driver;
  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  seg7_scan_driver_if bus ();
  seg7_scan_driver #(.SCAN_DIV(SD), .CNT_W(20)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Reference model: position in the scan follows purely from cycles since reset.
  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  function automatic logic [6:0] ref_seg(input logic [4:0] code);
    if (code < 5'd16) return ~PAT[code[3:0]];
    else if (code == 5'd17) return 7'h3F;
    else return 7'h7F;
  endfunction

  int              t;
  logic [4:0]      sh_code [4];
  logic [3:0]      sh_dp;
  logic [4:0]      in_code [4];
  logic [1:0]      nidx;
  logic [3:0]      exp_an;
  logic [6:0]      exp_seg;
  logic            exp_dpn, exp_ft;
  assign in_code = '{bus.oneIn, bus.tenIn, bus.hundIn, bus.thouIn};
  assign nidx    = 2'(((t + 1) / SD) % 4);

  always @(posedge clock) begin
    if (reset) begin
      t <= 0;
      sh_code <= '{5'd16, 5'd16, 5'd16, 5'd16};
      sh_dp <= 4'b0000;
      exp_an <= 4'hF; exp_seg <= 7'h7F; exp_dpn <= 1'b1; exp_ft <= 1'b0;
    end else begin
      t <= t + 1;
      exp_an <= bus.blank ? 4'hF : ~(4'b0001 << nidx);
      if (((t + 1) % FRAME) == 0) begin
        sh_code <= in_code; sh_dp <= bus.dp; exp_ft <= 1'b1;
        exp_seg <= ref_seg(in_code[nidx]); exp_dpn <= ~bus.dp[nidx];
      end else begin
        exp_ft <= 1'b0;
        exp_seg <= ref_seg(sh_code[nidx]); exp_dpn <= ~sh_dp[nidx];
      end
    end
  end

  // Every-cycle comparison against the model plus the never-two-hot anode rule.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if ($countones(~bus.an) > 1) begin
        errors++; $display("FAIL two_hot: an=%b", bus.an);
      end
      checks++;
      if ({bus.an, bus.seg, bus.dp_n, bus.frame_tick} !== {exp_an, exp_seg, exp_dpn, exp_ft}) begin
        errors++;
        $display("FAIL model t=%0d: an=%b seg=%h dp_n=%b ft=%b, want an=%b seg=%h dp_n=%b ft=%b",
                 t, bus.an, bus.seg, bus.dp_n, bus.frame_tick, exp_an, exp_seg, exp_dpn, exp_ft);
      end
    end
  end

  task automatic wait_tick(input string name);
    int n = 0;
    while (bus.frame_tick !== 1'b1 && n < 4 * FRAME) begin @(negedge clock); n++; end
    checks++;
    if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL %s_timeout: no frame_tick in %0d cycles", name, n); end
  endtask

  task automatic test_reset();
    int first = 0;
    bus.oneIn = 5'd16; bus.tenIn = 5'd16; bus.hundIn = 5'd16; bus.thouIn = 5'd16;
    bus.dp = 4'b0000; bus.blank = 1'b0; reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      mon_en = 1'b1;
      checks++;
      if ({bus.an, bus.seg, bus.dp_n, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++; $display("FAIL reset_outputs: an=%b seg=%h dp_n=%b ft=%b, want 1111 7f 1 0",
                           bus.an, bus.seg, bus.dp_n, bus.frame_tick);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= FRAME + 4; i++) begin
      @(negedge clock);
      if (bus.frame_tick === 1'b1 && first == 0) first = i;
      if (i == 1 || i == 5 || i == 9 || i == 13) begin
        checks++;
        if (bus.an !== ~(4'b0001 << ((i - 1) / SD))) begin
          errors++; $display("FAIL reset_walk cycle %0d: an=%b", i, bus.an);
        end
      end
      checks++;
      if (bus.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg cycle %0d: seg=%h want 7f", i, bus.seg); end
    end
    checks++;
    if (first != FRAME) begin errors++; $display("FAIL first_tick: at cycle %0d, want %0d", first, FRAME); end
  endtask

  task automatic test_digits();
    bus.oneIn = 5'd1; bus.tenIn = 5'd2; bus.hundIn = 5'd16; bus.thouIn = 5'd10; bus.dp = 4'b0001;
    @(negedge clock);
    wait_tick("digits");
    for (int i = 0; i < FRAME; i++) begin
      logic [6:0] want_seg;
      logic       want_dpn;
      case (bus.an)
        4'b1110: begin want_seg = 7'h79; want_dpn = 1'b0; end
        4'b1101: begin want_seg = 7'h24; want_dpn = 1'b1; end
        4'b1011: begin want_seg = 7'h7F; want_dpn = 1'b1; end
        default: begin want_seg = 7'h08; want_dpn = 1'b1; end
      endcase
      checks++;
      if (bus.seg !== want_seg || bus.dp_n !== want_dpn) begin
        errors++; $display("FAIL digits an=%b: seg=%h dp_n=%b, want %h %b", bus.an, bus.seg, bus.dp_n, want_seg, want_dpn);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_midframe_change();
    int n = 0;
    while (bus.an !== 4'b1101 && n < FRAME) begin @(negedge clock); n++; end
    bus.oneIn = 5'd7;
    @(negedge clock);
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < 2 * FRAME) begin
      if (bus.an === 4'b1110) begin
        checks++;
        if (bus.seg !== 7'h79) begin errors++; $display("FAIL midframe_hold: seg=%h want 79", bus.seg); end
      end
      @(negedge clock); n++;
    end
    checks++;
    if (bus.frame_tick !== 1'b1 || bus.seg !== 7'h78) begin
      errors++; $display("FAIL midframe_new: ft=%b seg=%h want 1 78", bus.frame_tick, bus.seg);
    end
  endtask

  task automatic test_blank();
    repeat (5) @(negedge clock);
    bus.blank = 1'b1;
    repeat (6) begin
      @(negedge clock);
      checks++;
      if (bus.an !== 4'hF) begin errors++; $display("FAIL blank_on: an=%b want 1111", bus.an); end
    end
    bus.blank = 1'b0;
    @(negedge clock);
    checks++;
    if ($countones(~bus.an) != 1) begin errors++; $display("FAIL blank_off: an=%b want one-hot low", bus.an); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (bus.an !== 4'b1011 && n < FRAME) begin @(negedge clock); n++; end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
      errors++; $display("FAIL reset_mid: an=%b seg=%h want 1111 7f", bus.an, bus.seg);
    end
    reset = 1'b0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clock);
      if (i < FRAME) begin
        checks++;
        if (bus.seg !== 7'h7F) begin errors++; $display("FAIL reset_mid_blank %0d: seg=%h want 7f", i, bus.seg); end
      end else begin
        checks++;
        if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL reset_mid_tick: ft=%b want 1", bus.frame_tick); end
      end
    end
  endtask

  task automatic test_codes();
    bus.oneIn = 5'd17; bus.tenIn = 5'd31;
    @(negedge clock);
    wait_tick("codes");
    for (int i = 0; i < 2 * SD; i++) begin
      if (bus.an === 4'b1110 || bus.an === 4'b1101) begin
        checks++;
        if (bus.seg !== ((bus.an === 4'b1110) ? 7'h3F : 7'h7F)) begin
          errors++; $display("FAIL codes an=%b: seg=%h", bus.an, bus.seg);
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    int ticks = 0;
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.oneIn = 5'($urandom_range(0, 31)); bus.tenIn = 5'($urandom_range(0, 31));
        bus.hundIn = 5'($urandom_range(0, 31)); bus.thouIn = 5'($urandom_range(0, 31));
        bus.dp = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) bus.blank = ~bus.blank;
      @(negedge clock);
      if (bus.frame_tick === 1'b1) ticks++;
    end
    bus.blank = 1'b0;
    checks++;
    if (ticks != 12) begin errors++; $display("FAIL random_ticks: %0d frame_ticks, want 12", ticks); end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_midframe_change();
    test_blank();
    test_reset_mid();
    test_codes();
    test_random();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
